vga_timing: RTL
===============

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, 1280, visible pixels per line.
REQ-002 Parameter H_FRONT, 48; H_SYNC, 112; H_BACK, 248: horizontal porch and sync widths in pixels, for a total of 1688.
REQ-003 Parameter V_ACTIVE, 1024, visible lines per frame.
REQ-004 Parameter V_FRONT, 1; V_SYNC, 3; V_BACK, 38: vertical porch and sync widths in lines, for a total of 1066.
REQ-005 Parameter SYNC_DELAY, 2, pipeline cycles applied to the delayed sync outputs, range 0..7.
REQ-006 Port clock, input, 1: pixel clock, 108 MHz.
REQ-007 Port reset, input, 1: synchronous, active-high.
REQ-008 Port pix_en, input, 1: pixel-advance enable; all counters hold when low.
REQ-009 Port display_col, output, 12: current horizontal count, 0..1687.
REQ-010 Port display_row, output, 11: current vertical count, 0..1065.
REQ-011 Port visible, output, 1: high while display_col < H_ACTIVE and display_row < V_ACTIVE.
REQ-012 Port frame_start, output, 1: one-cycle pulse at col 0, row 0.
REQ-013 Port line_start, output, 1: one-cycle pulse at col 0 of every line.
REQ-014 Port hsync_out, output, 1; vsync_out, output, 1; blank_out, output, 1: syncs and blank (the inverse of visible), delayed SYNC_DELAY cycles.

Function
REQ-015 The horizontal counter SHALL increment on each clock with pix_en=1 and wrap from 1687 to 0.
REQ-016 The vertical counter SHALL increment only when the horizontal counter wraps, and SHALL wrap from 1065 to 0 at that same edge.
REQ-017 A horizontal phase FSM SHALL hold states H_ACT (0..1279), H_FP (1280..1327), H_SY (1328..1439), H_BP (1440..1687), with transitions taken on the pix_en edge that reaches each boundary.
REQ-018 A vertical FSM SHALL use the same four phases: V_ACT (0..1023), V_FP (1024), V_SY (1025..1027), V_BP (1028..1065).
REQ-019 Undelayed hsync SHALL be high (positive polarity) in H_SY only, and vsync SHALL be high in V_SY only, for the entire line.
REQ-020 visible, display_col, display_row, frame_start and line_start SHALL all be registered and mutually consistent on the same cycle, with zero added latency relative to the counters.
REQ-021 frame_start and line_start SHALL be qualified by pix_en, so that they pulse at most once per counter position even if pix_en stalls there.
REQ-022 hsync_out, vsync_out and blank_out SHALL equal the undelayed values exactly SYNC_DELAY clock cycles earlier, counted in clock cycles, not pix_en cycles.
REQ-023 With SYNC_DELAY=0, the delayed outputs SHALL equal the undelayed values on the same cycle.
REQ-024 While pix_en=0, all outputs except the delay line SHALL hold their values, and the delay line SHALL keep shifting.
REQ-025 The FSM state and counters SHALL never disagree, and any illegal state SHALL recover to H_ACT/V_ACT on the next pix_en edge.

Reset
REQ-026 While reset is high, the counters SHALL be 0, both FSMs SHALL be in ACT, visible=1, frame_start=0, line_start=0, and all delay stages SHALL be 0.
REQ-027 hsync_out, vsync_out and blank_out SHALL therefore read 0 during reset.
REQ-028 On the first clock after reset deasserts with pix_en=1, frame_start and line_start SHALL pulse.
REQ-029 A mid-frame reset SHALL abort the frame immediately, with no completion of the current line.

Structure
REQ-030 A shared package vga_pkg SHALL hold the timing constants, the derived totals (1688, 1066), and the phase enum {ACT, FP, SY, BP}.
REQ-031 A single sub-module vga_phase_ctr (counter plus phase FSM, parameterised by the four widths) SHALL be instantiated twice, once horizontal and once vertical, with the vertical instance enabled by the horizontal wrap.
REQ-032 The delay line SHALL be a shift register inside vga_timing, 3 bits wide by SYNC_DELAY deep.

Verification
REQ-033 Reset release, pix_en=1 -> frame_start pulses at cycle 0; line_start pulses every 1688 cycles; frame_start pulses next at cycle 1,799,408.
REQ-034 Horizontal sync check -> hsync high exactly 112 cycles starting at col 1328; visible low from col 1280 to 1687.
REQ-035 Vertical sync check -> vsync high for rows 1025..1027 (5064 cycles); row wraps 1065->0 on the same edge as col 1687->0.
REQ-036 SYNC_DELAY=2 -> hsync_out rises exactly 2 clocks after internal hsync; with SYNC_DELAY=0 they are identical.
REQ-037 pix_en toggled at 50% while crossing col 1279->1280 and row 1023->1024 -> counters hold on low cycles; no duplicate line_start pulse; visible falls on the enabled edge.
REQ-038 Reset asserted at col 700, row 900 for 3 cycles -> outputs equal the reset values, and the next frame_start occurs on the first enabled cycle after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants and phase encoding for the VGA raster generator.
// Defaults describe 1280x1024 @ 60 Hz with a 108 MHz pixel clock.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FRONT  = 48;
    localparam int DEF_H_SYNC   = 112;
    localparam int DEF_H_BACK   = 248;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int DEF_V_ACTIVE = 1024;
    localparam int DEF_V_FRONT  = 1;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BACK   = 38;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int COL_W = 12;
    localparam int ROW_W = 11;

    typedef enum logic [1:0] {
        ACT = 2'd0,
        FP  = 2'd1,
        SY  = 2'd2,
        BP  = 2'd3
    } phase_e;

    // Phase a given count belongs to; used to detect a state/counter disagreement.
    function automatic phase_e phase_of(input int count, input int active,
                                        input int front, input int sync);
        if (count < active)
            return ACT;
        else if (count < active + front)
            return FP;
        else if (count < active + front + sync)
            return SY;
        else
            return BP;
    endfunction

endpackage

// File: rtl/vga_phase_ctr.sv
// One axis of the raster: a wrapping counter with a four-phase FSM that
// tracks active / front porch / sync / back porch.
module vga_phase_ctr
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK,
    parameter int W      = COL_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [1:0]   phase
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] FP_START = W'(ACTIVE);
    localparam logic [W-1:0] SY_START = W'(ACTIVE + FRONT);
    localparam logic [W-1:0] BP_START = W'(ACTIVE + FRONT + SYNC);

    logic [W-1:0] count_reg, count_next;
    phase_e       phase_reg, phase_next;
    logic         consistent;

    assign consistent = (phase_reg == phase_of(int'(count_reg), ACTIVE, FRONT, SYNC))
                        && (count_reg <= LAST);

    always_comb begin
        count_next = count_reg;
        phase_next = phase_reg;
        if (!consistent) begin
            // Upset state: restart the axis cleanly rather than run on with a mismatch.
            count_next = '0;
            phase_next = ACT;
        end else begin
            count_next = (count_reg == LAST) ? '0 : count_reg + W'(1);
            case (phase_reg)
                ACT:     if (count_next == FP_START) phase_next = FP;
                FP:      if (count_next == SY_START) phase_next = SY;
                SY:      if (count_next == BP_START) phase_next = BP;
                BP:      if (count_next == '0)       phase_next = ACT;
                default: phase_next = ACT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
            phase_reg <= ACT;
        end else if (en) begin
            count_reg <= count_next;
            phase_reg <= phase_next;
        end
    end

    assign count = count_reg;
    assign phase = phase_reg;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: horizontal/vertical counters, registered position and
// strobes, and a clock-cycle delay line for hsync/vsync/blank.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int SYNC_DELAY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_en,
    output logic [11:0] display_col,
    output logic [10:0] display_row,
    output logic        visible,
    output logic        frame_start,
    output logic        line_start,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    logic [COL_W-1:0] h_count;
    logic [ROW_W-1:0] v_count;
    logic [1:0]       h_phase, v_phase;
    logic             h_wrap;

    assign h_wrap = pix_en && (h_count == COL_W'(H_TOTAL - 1));

    vga_phase_ctr #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .W      (COL_W)
    ) u_h_ctr (
        .clock  (clock),
        .reset  (reset),
        .en     (pix_en),
        .count  (h_count),
        .phase  (h_phase)
    );

    vga_phase_ctr #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .W      (ROW_W)
    ) u_v_ctr (
        .clock  (clock),
        .reset  (reset),
        .en     (h_wrap),
        .count  (v_count),
        .phase  (v_phase)
    );

    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic             visible_reg, frame_start_reg, line_start_reg;
    logic             hsync_reg, vsync_reg, blank_reg;
    logic             visible_next;

    assign visible_next = (h_phase == ACT) && (v_phase == ACT);

    // Outputs show the position consumed on each enabled edge, so every strobe
    // lines up with the col/row it describes and pulses once per position.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_reg         <= '0;
            row_reg         <= '0;
            visible_reg     <= 1'b1;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
            hsync_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            blank_reg       <= 1'b0;
        end else if (pix_en) begin
            col_reg         <= h_count;
            row_reg         <= v_count;
            visible_reg     <= visible_next;
            frame_start_reg <= (h_count == '0) && (v_count == '0);
            line_start_reg  <= (h_count == '0);
            hsync_reg       <= (h_phase == SY);
            vsync_reg       <= (v_phase == SY);
            blank_reg       <= !visible_next;
        end else begin
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
        end
    end

    assign display_col = col_reg;
    assign display_row = row_reg;
    assign visible     = visible_reg;
    assign frame_start = frame_start_reg;
    assign line_start  = line_start_reg;

    logic [2:0] sync_now;
    assign sync_now = {hsync_reg, vsync_reg, blank_reg};

    // Delay counts raw clocks, independent of pix_en.
    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign {hsync_out, vsync_out, blank_out} = sync_now;
        end else begin : g_delay
            logic [2:0] dly_reg [SYNC_DELAY];

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_DELAY; i++)
                        dly_reg[i] <= '0;
                end else begin
                    dly_reg[0] <= sync_now;
                    for (int i = 1; i < SYNC_DELAY; i++)
                        dly_reg[i] <= dly_reg[i-1];
                end
            end

            assign {hsync_out, vsync_out, blank_out} = dly_reg[SYNC_DELAY-1];
        end
    endgenerate

endmodule
